// File: rtl/m_cp0_pkg.sv
// m_cp0_pkg: CP0 register numbers, exception codes and default constants shared by the CP0 slice.
package m_cp0_pkg;
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_SR      = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam logic [4:0] CP0_PRID    = 5'd15;
    typedef enum logic [4:0] {
        EXC_INT     = 5'd0,
        EXC_ADEL    = 5'd4,
        EXC_ADES    = 5'd5,
        EXC_SYSCALL = 5'd8,
        EXC_RI      = 5'd10,
        EXC_OV      = 5'd12
    } exc_code_e;
    localparam logic [31:0] PRID_DEFAULT    = 32'h2023_0321;
    localparam logic [31:0] HANDLER_DEFAULT = 32'h0000_4180;
    // A delay-slot victim restarts at its branch, one word earlier.
    function automatic logic [31:0] f_epc(input logic [31:0] vpc, input logic bd);
        return (vpc & 32'hFFFF_FFFC) - (bd ? 32'd4 : 32'd0);
    endfunction
endpackage

// File: rtl/m_cp0_if.sv
// m_cp0_if: M-stage pipeline <-> CP0 signal bundle; master is the pipeline, slave is CP0.
interface m_cp0_if;
    logic        i_en;
    logic [4:0]  i_cp0_add;
    logic [31:0] i_cp0_in;
    logic [31:0] i_vpc;
    logic        i_bd_in;
    logic [4:0]  i_exc_code_in;
    logic [5:0]  i_hw_int;
    logic        i_exl_clr;
    logic [31:0] o_cp0_out;
    logic [31:0] o_epc_out;
    logic [31:0] o_handler_pc;
    logic        o_req;
    modport master (
        output i_en, i_cp0_add, i_cp0_in, i_vpc, i_bd_in, i_exc_code_in, i_hw_int, i_exl_clr,
        input  o_cp0_out, o_epc_out, o_handler_pc, o_req
    );
    modport slave (
        input  i_en, i_cp0_add, i_cp0_in, i_vpc, i_bd_in, i_exc_code_in, i_hw_int, i_exl_clr,
        output o_cp0_out, o_epc_out, o_handler_pc, o_req
    );
endinterface

// File: rtl/m_cp0_timer.sv
// m_cp0_timer: free-running Count, writable Compare and the sticky TimerPend flag.
module m_cp0_timer (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_we_count,
    input  logic        i_we_compare,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_pend
);
    logic [31:0] r_count, r_compare;
    logic        r_pend, r_moved;
    // r_moved masks the trivial 0==0 match that exists straight out of reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count   <= 32'd0;
            r_compare <= 32'd0;
            r_pend    <= 1'b0;
            r_moved   <= 1'b0;
        end else begin
            r_count   <= i_we_count ? i_wdata : r_count + 32'd1;
            r_compare <= i_we_compare ? i_wdata : r_compare;
            r_pend    <= ~i_we_compare & (r_pend | (r_moved & (r_count == r_compare)));
            r_moved   <= 1'b1;
        end
    end
    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_pend    = r_pend;
endmodule

// File: rtl/m_cp0.sv
// m_cp0: M-stage coprocessor 0 (SR, Cause, EPC, PRId) producing the single flush/redirect request.
// Optional timer (Count/Compare on HWInt[5]) is built when CP0_TIMER_EN is defined.
module m_cp0
    import m_cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_DEFAULT
) (
    input logic    i_clk,
    input logic    i_reset,
    m_cp0_if.slave bus
);
    logic [5:0]  r_im, r_ip;
    logic        r_exl, r_ie, r_bd;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;
    logic [31:0] w_sr, w_cause, w_count, w_compare;
    logic [5:0]  w_hw_int;
    logic        w_int_req, w_req, w_wr, w_tpend;
    assign w_sr      = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause   = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};
    assign w_int_req = (|(r_ip & r_im)) & r_ie & ~r_exl;
    assign w_req     = ~i_reset & (w_int_req | ((bus.i_exc_code_in != EXC_INT) & ~r_exl));
    assign w_wr      = bus.i_en & ~w_req;
    assign w_hw_int  = bus.i_hw_int | {w_tpend, 5'd0};
`ifdef CP0_TIMER_EN
    m_cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_we_count   (w_wr && bus.i_cp0_add == CP0_COUNT),
        .i_we_compare (w_wr && bus.i_cp0_add == CP0_COMPARE),
        .i_wdata      (bus.i_cp0_in),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_pend       (w_tpend)
    );
`else
    assign w_count   = 32'd0;
    assign w_compare = 32'd0;
    assign w_tpend   = 1'b0;
`endif
    // IP samples unconditionally; a taken request outranks both mtc0 and eret.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_im       <= 6'd0;
            r_ip       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= w_hw_int;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bus.i_bd_in;
                r_exc_code <= w_int_req ? EXC_INT : bus.i_exc_code_in;
                r_epc      <= f_epc(bus.i_vpc, bus.i_bd_in);
            end else begin
                if (w_wr && bus.i_cp0_add == CP0_SR) begin
                    r_im  <= bus.i_cp0_in[15:10];
                    r_exl <= bus.i_cp0_in[1];
                    r_ie  <= bus.i_cp0_in[0];
                end
                if (w_wr && bus.i_cp0_add == CP0_EPC) r_epc <= bus.i_cp0_in;
                if (bus.i_exl_clr) r_exl <= 1'b0;
            end
        end
    end
    always_comb begin
        bus.o_cp0_out = bus.i_cp0_add == CP0_SR      ? w_sr      :
                        bus.i_cp0_add == CP0_CAUSE   ? w_cause   :
                        bus.i_cp0_add == CP0_EPC     ? r_epc     :
                        bus.i_cp0_add == CP0_PRID    ? PRID_VALUE :
                        bus.i_cp0_add == CP0_COUNT   ? w_count   :
                        bus.i_cp0_add == CP0_COMPARE ? w_compare : 32'd0;
    end
    assign bus.o_epc_out    = r_epc;
    assign bus.o_handler_pc = HANDLER_PC;
    assign bus.o_req        = w_req;
endmodule
